// File: rtl/scan_7segment_capture.sv
// Receive-side monitor for the multiplexed 7-segment bus: rebuilds the four
// scanned hex digits into a 16-bit frame and flags bad patterns and stalls.
module scan_7segment_capture #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        FPGA_clk,
  input  logic        clr,
  input  logic [3:0]  ScanEn,
  input  logic [7:0]  Segs,
  output logic [15:0] Dout,
  output logic [3:0]  Dp,
  output logic        Valid,
  output logic        Err,
  output logic        Stall
);

  localparam logic [7:0]  SETTLE_C  = 8'(SETTLE);
  localparam logic [19:0] TIMEOUT_C = 20'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  state_t state, state_next;

  logic [3:0] se_s1, se_s2, se_prev;
  logic [7:0] sg_s1, sg_s2, sg_prev;
  logic [7:0] cnt, cnt_next;
  logic       sample;
  logic       sel_valid;
  logic [1:0] sel_idx;
  logic       se_changed, any_changed;

  logic [3:0]       dec_nib;
  logic             dec_err;
  logic [3:0][3:0]  sh_nib, nib_n;
  logic [3:0]       sh_dp, dp_n;
  logic [3:0]       sh_err, err_n;
  logic [3:0]       mask, mask_n;
  logic             frame_done;
  logic [19:0]      wd;

  always_ff @(posedge FPGA_clk or negedge clr) begin
    if (!clr) begin
      se_s1   <= '0;
      se_s2   <= '0;
      se_prev <= '0;
      sg_s1   <= '0;
      sg_s2   <= '0;
      sg_prev <= '0;
    end else begin
      se_s1   <= ScanEn;
      se_s2   <= se_s1;
      se_prev <= se_s2;
      sg_s1   <= Segs;
      sg_s2   <= sg_s1;
      sg_prev <= sg_s2;
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = 2'd0;
    case (se_s2)
      4'b1110: begin sel_valid = 1'b1; sel_idx = 2'd0; end
      4'b1101: begin sel_valid = 1'b1; sel_idx = 2'd1; end
      4'b1011: begin sel_valid = 1'b1; sel_idx = 2'd2; end
      4'b0111: begin sel_valid = 1'b1; sel_idx = 2'd3; end
      default: begin sel_valid = 1'b0; sel_idx = 2'd0; end
    endcase
  end

  assign se_changed  = (se_s2 != se_prev);
  assign any_changed = se_changed || (sg_s2 != sg_prev);

  always_comb begin
    dec_err = 1'b0;
    dec_nib = 4'h0;
    case (sg_s2[6:0])
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
      default: begin dec_nib = 4'h0; dec_err = 1'b1; end
    endcase
  end

  always_ff @(posedge FPGA_clk or negedge clr) begin
    if (!clr) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The cycle in which a new select first appears counts as stable cycle 1,
  // so the settle check is applied after the per-state transition.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sample     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_valid) begin
          state_next = ST_SETTLE;
          cnt_next   = 8'd1;
        end
      end
      ST_SETTLE: begin
        if (!sel_valid) begin
          state_next = ST_IDLE;
        end else if (any_changed) begin
          cnt_next = 8'd1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      ST_HOLD: begin
        if (se_changed) begin
          if (sel_valid) begin
            state_next = ST_SETTLE;
            cnt_next   = 8'd1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (state_next == ST_SETTLE && cnt_next >= SETTLE_C) begin
      sample     = 1'b1;
      state_next = ST_HOLD;
    end
  end

  always_comb begin
    nib_n  = sh_nib;
    dp_n   = sh_dp;
    err_n  = sh_err;
    mask_n = mask;
    if (sample) begin
      nib_n[sel_idx]  = dec_nib;
      dp_n[sel_idx]   = ~sg_s2[7];
      err_n[sel_idx]  = dec_err;
      mask_n[sel_idx] = 1'b1;
    end
    frame_done = sample && (mask_n == 4'b1111);
  end

  // The frame is published on the same edge that stores the fourth digit,
  // so the mask itself never holds 1111.
  always_ff @(posedge FPGA_clk or negedge clr) begin
    if (!clr) begin
      sh_nib <= '0;
      sh_dp  <= '0;
      sh_err <= '0;
      mask   <= '0;
      Dout   <= '0;
      Dp     <= '0;
      Err    <= 1'b0;
      Valid  <= 1'b0;
    end else begin
      sh_nib <= nib_n;
      sh_dp  <= dp_n;
      sh_err <= err_n;
      mask   <= frame_done ? 4'b0000 : mask_n;
      Valid  <= frame_done;
      if (frame_done) begin
        Dout <= nib_n;
        Dp   <= dp_n;
        Err  <= |err_n;
      end
    end
  end

  always_ff @(posedge FPGA_clk or negedge clr) begin
    if (!clr) begin
      wd <= '0;
    end else if (sel_valid) begin
      wd <= '0;
    end else if (wd != TIMEOUT_C) begin
      wd <= wd + 20'd1;
    end
  end

  always_comb begin
    Stall = (wd == TIMEOUT_C) && !sel_valid;
  end

endmodule
